// File: rtl/switch_debounce_filter.sv
// Per-channel switch debouncer: two-flop synchronizer, stable-count filter,
// registered level, rise/fall pulses and a press-toggle level.
module switch_debounce_filter #(
  parameter int unsigned NUM_SW         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Rise,
  output logic [NUM_SW-1:0] o_Fall,
  output logic [NUM_SW-1:0] o_Toggle
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]   LIMIT_M1 = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_SW-1:0] meta;
  logic [NUM_SW-1:0] sync;

  // Two-flop synchronizer; only sync is used downstream.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= i_Switch;
      sync <= meta;
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             rise;
    logic             fall;
    logic             tog;
    logic             differ_c;
    logic             done_c;

    assign differ_c = sync[g] ^ stable;
    assign done_c   = differ_c && (cnt == LIMIT_M1);

    // Counter saturates at the accept point and clears whenever sync
    // agrees with the stable level, so it can never wrap.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        cnt    <= '0;
        stable <= 1'b0;
        rise   <= 1'b0;
        fall   <= 1'b0;
        tog    <= 1'b0;
      end else begin
        rise <= done_c & sync[g];
        fall <= done_c & ~sync[g];
        if (!differ_c) begin
          cnt <= '0;
        end else if (done_c) begin
          cnt    <= '0;
          stable <= sync[g];
          if (sync[g]) begin
            tog <= ~tog;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign o_Switch[g] = stable;
    assign o_Rise[g]   = rise;
    assign o_Fall[g]   = fall;
    assign o_Toggle[g] = tog;
  end

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Table-driven bench for switch_debounce_filter (NUM_SW=4, DEBOUNCE_LIMIT=4)
// with a scoreboard queue holding the expected outputs of each driven vector.
module tb_switch_debounce_filter;

  localparam int unsigned N = 4;
  localparam int unsigned L = 4;

  typedef struct {
    logic [3:0] pin;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tog;
    string      tag;
  } vec_t;

  logic         i_Clk    = 1'b0;
  logic         i_Rst_L  = 1'b1;
  logic [N-1:0] i_Switch = '0;
  logic [N-1:0] o_Switch;
  logic [N-1:0] o_Rise;
  logic [N-1:0] o_Fall;
  logic [N-1:0] o_Toggle;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  switch_debounce_filter #(
    .NUM_SW        (N),
    .DEBOUNCE_LIMIT(L)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise  (o_Rise),
    .o_Fall  (o_Fall),
    .o_Toggle(o_Toggle)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  function automatic void add(input logic [3:0] pin, input int reps,
                              input logic [3:0] sw, input logic [3:0] rise,
                              input logic [3:0] fall, input logic [3:0] tog,
                              input string tag);
    vec_t v;
    v.pin  = pin;
    v.sw   = sw;
    v.rise = rise;
    v.fall = fall;
    v.tog  = tog;
    v.tag  = tag;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  task automatic check_now(input string tag, input logic [3:0] sw, input logic [3:0] rise,
                           input logic [3:0] fall, input logic [3:0] tog);
    n_cmp++;
    if ({o_Switch, o_Rise, o_Fall, o_Toggle} !== {sw, rise, fall, tog}) begin
      n_bad++;
      $display("FAIL %s @%0t: got sw=%h rise=%h fall=%h tog=%h, want sw=%h rise=%h fall=%h tog=%h",
               tag, $time, o_Switch, o_Rise, o_Fall, o_Toggle, sw, rise, fall, tog);
    end
  endtask

  // Drive one vector, record its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    i_Switch = v.pin;
    sb.push_back(v);
    @(posedge i_Clk);
    #1;
    e = sb.pop_front();
    check_now(e.tag, e.sw, e.rise, e.fall, e.tog);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // Reset held with all pins pressed: outputs stay 0, even before any edge.
    i_Switch = 4'hF;
    i_Rst_L  = 1'b0;
    #2;
    check_now("reset_pre_clk", 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) begin
      @(posedge i_Clk);
      #1;
      check_now("reset_held", 4'h0, 4'h0, 4'h0, 4'h0);
    end
    i_Switch = 4'h0;
    i_Rst_L  = 1'b1;

    // Clean press on channel 0: accepted at edge 6.
    add(4'b0001, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "press0_wait");
    add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "press0_accept");
    add(4'b0001, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "press0_hold");
    // Bounce on channel 1: high 3, low 1, then held high.
    add(4'b0011, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "bounce1_hi");
    add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "bounce1_lo");
    add(4'b0011, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "bounce1_wait");
    add(4'b0011, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0011, "bounce1_accept");
    add(4'b0011, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0011, "bounce1_hold");
    // Channel 2: press, release, press.
    add(4'b0111, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0011, "ch2_press_wait");
    add(4'b0111, 1, 4'b0111, 4'b0100, 4'b0000, 4'b0111, "ch2_rise1");
    add(4'b0011, 5, 4'b0111, 4'b0000, 4'b0000, 4'b0111, "ch2_rel_wait");
    add(4'b0011, 1, 4'b0011, 4'b0000, 4'b0100, 4'b0111, "ch2_fall");
    add(4'b0111, 5, 4'b0011, 4'b0000, 4'b0000, 4'b0111, "ch2_press2_wait");
    add(4'b0111, 1, 4'b0111, 4'b0100, 4'b0000, 4'b0011, "ch2_rise2");
    add(4'b0111, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0011, "ch2_hold");
    // Channel 3 begins counting; count reaches 2 after four edges.
    add(4'b1111, 4, 4'b0111, 4'b0000, 4'b0000, 4'b0011, "ch3_partial");
    run_vecs();

    // One-cycle reset pulse mid-count clears everything asynchronously.
    i_Rst_L = 1'b0;
    #1;
    check_now("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge i_Clk);
    #1;
    check_now("rst_edge", 4'h0, 4'h0, 4'h0, 4'h0);
    i_Rst_L = 1'b1;

    // After release with all pressed: full 2 + L edges before acceptance.
    add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "post_rst_wait");
    add(4'b1111, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, "post_rst_accept");
    add(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "post_rst_hold");
    // Glitch of L-1 sync cycles on channel 0 is ignored.
    add(4'b1110, 3, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "glitch3_lo");
    add(4'b1111, 5, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "glitch3_hi");
    // Exactly L sync cycles low is accepted; pulses land L cycles apart.
    add(4'b1110, 4, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "exact4_lo");
    add(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "exact4_wait");
    add(4'b1111, 1, 4'b1110, 4'b0000, 4'b0001, 4'b1111, "exact4_fall");
    add(4'b1111, 3, 4'b1110, 4'b0000, 4'b0000, 4'b1111, "exact4_gap");
    add(4'b1111, 1, 4'b1111, 4'b0001, 4'b0000, 4'b1110, "exact4_rise");
    add(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1110, "exact4_hold");
    // Simultaneous release then press on all channels.
    add(4'b0000, 5, 4'b1111, 4'b0000, 4'b0000, 4'b1110, "all_rel_wait");
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b1111, 4'b1110, "all_fall");
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1110, "all_rel_hold");
    add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0000, 4'b1110, "all_press_wait");
    add(4'b1111, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0001, "all_rise");
    add(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, "all_press_hold");
    run_vecs();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
